// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_pkg;

  // Arbiter control state.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_e;

  // Ceiling log2, used to size encoded requester indices.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req at or above start, wrapping.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Duplicate the request vector and mask off bits below start, so a plain
  // low-to-high priority scan over 2N bits implements the wrap-around.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(start));
    end
  end

  // First set bit of the masked vector, folded back into 0..N-1.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (masked[j] && !found) begin
        found          = 1'b1;
        idx            = IDW'(j % N);
        onehot         = '0;
        onehot[j % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant outstanding; next request picked starting at ptr
//   GRANT | holder gnt_id owns the resource; credit = extra cycles left
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int N   = 4,
  parameter int WW  = 3,
  parameter int IDW = clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*WW-1:0]   weight,
  output logic [N-1:0]      granto,
  output logic [IDW-1:0]    gnt_id,
  output logic              gnt_valid
);

  wrr_state_e     state;
  logic [IDW-1:0] ptr;
  logic [WW-1:0]  credit;

  logic [IDW-1:0] nxt_id;
  logic [IDW-1:0] pick_start;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic [WW-1:0]  win_field;
  logic [WW-1:0]  win_credit;

  // Rotation start: after the holder when rotating, else the stored pointer.
  always_comb begin
    nxt_id     = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    pick_start = (state == GRANT) ? nxt_id : ptr;
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Credit loaded for the winner: effective weight minus the granting cycle,
  // with a zero weight behaving as one.
  always_comb begin
    win_field  = weight[pick_idx*WW +: WW];
    win_credit = (win_field == '0) ? '0 : win_field - 1'b1;
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      granto    <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      credit    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            granto    <= pick_onehot;
            gnt_id    <= pick_idx;
            gnt_valid <= 1'b1;
            credit    <= win_credit;
          end
        end
        GRANT: begin
          if (req[gnt_id] && (credit != '0)) begin
            credit <= credit - 1'b1;
          end else begin
            ptr <= nxt_id;
            if (pick_found) begin
              granto    <= pick_onehot;
              gnt_id    <= pick_idx;
              gnt_valid <= 1'b1;
              credit    <= win_credit;
            end else begin
              state     <= IDLE;
              granto    <= '0;
              gnt_id    <= '0;
              gnt_valid <= 1'b0;
              credit    <= '0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          granto    <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          credit    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (N=4, WW=3).
module tb_wrr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 3;
  localparam int IDW = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*WW-1:0]   weight;
  logic [N-1:0]      granto;
  logic [IDW-1:0]    gnt_id;
  logic              gnt_valid;

  int pass_cnt;
  int total_cnt;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .granto    (granto),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle reset; returns at a falling edge with the arbiter idle.
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    rst = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total_cnt++;
      if (granto !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
        $display("FAIL reset_hold cyc%0d: granto=%b valid=%b id=%0d, want 0000/0/0", c, granto, gnt_valid, gnt_id);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1)
      $display("FAIL reset_first: granto=%b id=%0d valid=%b, want 0001/0/1", granto, gnt_id, gnt_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [IDW-1:0] exp_id;
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_id = IDW'(k % 4);
      exp_g  = 4'b0001 << (k % 4);
      total_cnt++;
      if (granto !== exp_g || gnt_id !== exp_id || gnt_valid !== 1'b1)
        $display("FAIL rr cyc%0d: granto=%b id=%0d valid=%b, want %b/%0d/1", k, granto, gnt_id, gnt_valid, exp_g, exp_id);
      else pass_cnt++;
    end
  endtask

  task automatic test_weighted();
    int exp_seq [7];
    logic [N-1:0] exp_g;
    exp_seq = '{0, 0, 1, 2, 2, 2, 3};
    do_reset();
    weight = {3'd0, 3'd3, 3'd1, 3'd2};
    req = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp_g = 4'b0001 << exp_seq[k % 7];
      total_cnt++;
      if (granto !== exp_g || gnt_id !== IDW'(exp_seq[k % 7]))
        $display("FAIL weighted cyc%0d: granto=%b id=%0d, want %b/%0d", k, granto, gnt_id, exp_g, exp_seq[k % 7]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lone();
    do_reset();
    weight = {3'd1, 3'd2, 3'd1, 3'd1};
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total_cnt++;
      if (granto !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1)
        $display("FAIL lone cyc%0d: granto=%b id=%0d valid=%b, want 0100/2/1", k, granto, gnt_id, gnt_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_early_release();
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd4};
    req = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (granto !== 4'b0001 || gnt_id !== 2'd0)
        $display("FAIL early_hold cyc%0d: granto=%b id=%0d, want 0001/0", k, granto, gnt_id);
      else pass_cnt++;
    end
    req = 4'b1000;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b1000 || gnt_id !== 2'd3 || gnt_valid !== 1'b1)
      $display("FAIL early_switch: granto=%b id=%0d valid=%b, want 1000/3/1", granto, gnt_id, gnt_valid);
    else pass_cnt++;
    req = 4'b0000;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0)
      $display("FAIL early_idle: granto=%b id=%0d valid=%b, want 0000/0/0", granto, gnt_id, gnt_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    weight = {3'd1, 3'd3, 3'd1, 3'd1};
    req = 4'b0100;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b0100 || gnt_id !== 2'd2)
      $display("FAIL midrst_pre: granto=%b id=%0d, want 0100/2", granto, gnt_id);
    else pass_cnt++;
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL midrst_reset: granto=%b valid=%b id=%0d, want 0000/0/0", granto, gnt_valid, gnt_id);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (granto !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1)
      $display("FAIL midrst_after: granto=%b id=%0d valid=%b, want 0001/0/1", granto, gnt_id, gnt_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst    = 1'b1;
    req    = '0;
    weight = '0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_lone();
    test_early_release();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter: successor to the fixed 4-requester round-robin arbiter.
- Arbitrates N requesters onto one shared resource.
- Each requester holds the grant for up to its programmed weight in consecutive cycles, then ownership rotates.
- Sits in front of shared buses or memories.
- Grant is registered and one-hot, with an encoded index and valid flag.

Parameters:
- N, 4, number of requesters (N >= 2).
- WW, 3, width of each per-requester weight field.
- IDW, $clog2(N), width of the encoded grant index (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit i = requester i.
- weight  in  N*WW  weights; requester i uses weight[i*WW +: WW]; sampled at grant load.
- granto  out  N  registered one-hot grant; all zeros when idle.
- gnt_id  out  IDW  binary index of the current holder; 0 when idle.
- gnt_valid  out  1  high when granto is non-zero.

Behaviour:
- Reset (rst=1 at an edge):
  - granto=0, gnt_id=0, gnt_valid=0.
  - Rotation pointer ptr=0, credit counter=0.
  - Reset wins over all other activity, including mid-grant.
- Effective weight: ew(i) = weight field, except a field of 0 is treated as 1.
- Pick function: first set bit of req, scanning from index s upward with wrap modulo N. The scan includes s and ends at s-1.
- State IDLE (gnt_valid=0), at each edge:
  - If req is all zeros: stay IDLE.
  - Else pick from s=ptr. Grant winner w: granto=1<<w, gnt_id=w, gnt_valid=1, credit=ew(w)-1. Go to GRANT.
- State GRANT, holder h, at each edge:
  - Hold: if req[h]=1 and credit>0, then credit decrements and the grant is unchanged.
  - Rotate: if req[h]=0 or credit=0, then ptr=(h+1) mod N and pick from s=(h+1) mod N.
    - h itself is eligible last, if still requesting.
    - On a winner: load the new grant and credit in the same edge, with zero idle cycles between owners.
    - On no winner: go IDLE with granto=0.
- Latency: req sampled at edge k; granto reflects it after edge k (one-cycle registered latency).
- Continuously requesting holder with weight w: exactly w consecutive grant cycles when others request. With no other requesters it is re-granted back-to-back indefinitely.
- Holder dropping req: loses the grant at the next edge, even with credit remaining.
- Non-holders changing req mid-grant: no effect until rotation.
- Weight changes mid-grant: ignored until the next grant load.
- Outputs are purely registered. granto is always one-hot or zero. gnt_id always matches granto.

Decomposition:
- Package wrr_pkg: IDW derivation helper (clog2 function), and the state enum {IDLE, GRANT}.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], start[IDW].
  - Outputs: found, idx[IDW], onehot[N].
  - Implemented as a double-width masked priority encode.
  - wrr_arbiter instantiates it once; it is reusable by other arbiters.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> granto=0000, gnt_valid=0 during reset. First edge after release gives granto=0001, gnt_id=0.
- Plain round robin: all weights=1, req=1111 held -> granto cycles 0001,0010,0100,1000,0001..., one cycle each, with no idle gaps.
- Weighted: w0=2, w1=1, w2=3, w3=0, req=1111 held -> 0001 x2, 0010 x1, 0100 x3, 1000 x1 (zero treated as 1). The 7-cycle pattern repeats.
- Lone requester: req=0100, w2=2 -> granto stays 0100 every cycle across credit expiry. gnt_valid never drops.
- Early release: w0=4, req=0001 granted; two cycles later req=1000 -> next edge granto=1000, gnt_id=3. When req=0000, granto=0000 and gnt_valid=0 one edge later.
- Reset mid-grant: holder 2 with credit left, rst pulsed 1 cycle, then req=1111 -> granto=0000 after the reset edge, then 0001 (pointer reset to 0).
